mem_port_arbiter: RTL

- Shares the single RV32I memory port (mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata, mem_resp/mem_rdata) between two requesters.
- Requesters: instruction-fetch (I side) and load/store (D side).
- Sits between the CPU core and the memory model.
- Serialises accesses and latches each request for its whole lifetime.
- Routes the response back only to the requester that owns the transaction.

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single RV32I memory port between the instruction-fetch (I)
//   requester and the load/store (D) requester. One transaction is in
//   flight at a time; the winning request is latched at the granting edge
//   and drives the memory port until mem_resp. The completion pulse and
//   read data are routed back only to the owner of the transaction.
//
// Parameters
//   RR_EN  1: round-robin on simultaneous requests; 0: D side wins ties
//   WIDTH  address/data width
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   i_read, i_address            I-side read request
//   i_resp, i_rdata              I-side completion pulse / read data
//   d_read, d_write              D-side read / write request
//   d_byte_enable, d_address,
//   d_wdata                      D-side request payload
//   d_resp, d_rdata              D-side completion pulse / read data
//   mem_read, mem_write,
//   mem_byte_enable,
//   mem_address, mem_wdata       downstream request (from latched values)
//   mem_resp, mem_rdata          downstream completion / read data
module mem_port_arbiter #(
  parameter bit          RR_EN = 1'b1,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_read,
  input  logic [WIDTH-1:0] i_address,
  output logic             i_resp,
  output logic [WIDTH-1:0] i_rdata,
  input  logic             d_read,
  input  logic             d_write,
  input  logic [3:0]       d_byte_enable,
  input  logic [WIDTH-1:0] d_address,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_resp,
  output logic [WIDTH-1:0] d_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [3:0]       mem_byte_enable,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_resp,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             last_grant_d;
  logic             lat_write;
  logic [WIDTH-1:0] lat_address;
  logic [WIDTH-1:0] lat_wdata;
  logic [3:0]       lat_be;

  logic i_pend;
  logic d_pend;
  logic busy;
  logic done;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;
  assign busy   = (state != IDLE);
  // A reset edge aborts the transaction, so a mem_resp coinciding with it
  // must not reach the requester.
  assign done   = busy & mem_resp & ~rst;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (i_pend && d_pend) begin
          // Round-robin: give the tie to the side that did not win last.
          state_next = (RR_EN && last_grant_d) ? GNT_I : GNT_D;
        end else if (i_pend) begin
          state_next = GNT_I;
        end else if (d_pend) begin
          state_next = GNT_D;
        end
      end
      GNT_I, GNT_D: begin
        if (mem_resp) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      lat_write    <= 1'b0;
      lat_address  <= '0;
      lat_wdata    <= '0;
      lat_be       <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (state_next == GNT_I) begin
          lat_write   <= 1'b0;
          lat_address <= i_address;
          lat_wdata   <= '0;
          lat_be      <= '1;
        end else if (state_next == GNT_D) begin
          // d_read together with d_write is illegal; the write wins.
          lat_write   <= d_write;
          lat_address <= d_address;
          lat_wdata   <= d_wdata;
          lat_be      <= d_byte_enable;
        end
      end
      if (busy && mem_resp) begin
        last_grant_d <= (state == GNT_D);
      end
    end
  end

  assign mem_read        = busy & ~lat_write;
  assign mem_write       = busy & lat_write;
  assign mem_byte_enable = lat_be;
  assign mem_address     = lat_address;
  assign mem_wdata       = lat_wdata;

  assign i_resp  = done & (state == GNT_I);
  assign d_resp  = done & (state == GNT_D);
  assign i_rdata = i_resp ? mem_rdata : '0;
  assign d_rdata = d_resp ? mem_rdata : '0;

endmodule
